// File: rtl/ps2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : ps2_pkg                                                |
// | Brief   : Shared constants and types for the PS/2 receive path.  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package ps2_pkg;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ps2_event_fifo                                         |
// | Brief   : Synchronous event FIFO with fill level, valid/ready    |
// |           read port and a sticky overflow flag.                  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = $bits(ps2_event_t)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == (AW+1)'(DEPTH));
  assign w_pop   = pop_i & ~w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push  = push_i & (~w_full | w_pop);

  // Storage array; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers, fill level and sticky overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (w_push & ~w_pop)      count_q <= count_q + (AW+1)'(1);
      else if (w_pop & ~w_push) count_q <= count_q - (AW+1)'(1);
      if (push_i & w_full & ~w_pop) overflow_q <= 1'b1;
    end
  end

  assign rdata_o    = w_empty ? '0 : mem_q[rd_ptr_q];
  assign valid_o    = ~w_empty;
  assign full_o     = w_full;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_event_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ps2_rx_event_queue                                     |
// | Brief   : PS/2 keyboard receiver: synchroniser, clock filter,    |
// |           frame FSM with timeout, optional E0/F0 prefix folding  |
// |           (enabled by PS2_EXT_DECODE_EN) and an event FIFO.      |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module ps2_rx_event_queue
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DATA,
  output logic [9:0]                    EV_DATA,
  output logic                          EV_VALID,
  input  logic                          EV_READY,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          PARITY_ERR,
  output logic                          FRAME_ERR,
  output logic                          OVERFLOW,
  output logic                          BUSY
);

  localparam int FW        = $clog2(FILTER_LEN + 1);
  localparam int TW        = $clog2(TIMEOUT_CYC + 1);
  localparam int DATA_BITS = PS2_FRAME_BITS - 3;

  logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic filt_q;
  logic [FW-1:0] flt_cnt_q;
  logic w_fall;

  rx_state_t  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       push_q, push_d;
  ps2_event_t push_ev_q, push_ev_d;
`ifdef PS2_EXT_DECODE_EN
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
`endif

  logic w_fifo_full;

  // Two-flop synchronisers; lines idle high.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= PS2_DATA;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Glitch filter: flip the filtered clock after FILTER_LEN differing samples.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
    end else if (clk_sync_q == filt_q) begin
      flt_cnt_q <= '0;
    end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_q    <= clk_sync_q;
      flt_cnt_q <= '0;
    end else begin
      flt_cnt_q <= flt_cnt_q + FW'(1);
    end
  end

  assign w_fall = filt_q & ~clk_sync_q & (flt_cnt_q == FW'(FILTER_LEN - 1));

  // Frame FSM state and decode-result registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      push_q    <= 1'b0;
      push_ev_q <= '0;
`ifdef PS2_EXT_DECODE_EN
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      push_q    <= push_d;
      push_ev_q <= push_ev_d;
`ifdef PS2_EXT_DECODE_EN
      ext_q     <= ext_d;
      brk_q     <= brk_d;
`endif
    end
  end

  // Next-state logic: bit capture, frame check, timeout and prefix folding.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = '0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    push_d    = 1'b0;
    push_ev_d = '0;
`ifdef PS2_EXT_DECODE_EN
    ext_d     = ext_q;
    brk_d     = brk_q;
`endif

    // Mid-frame watchdog; only counts while no falling edge arrives.
    if (state_q != IDLE && !w_fall) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        ferr_d  = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (w_fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_sync_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_sync_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_sync_q) begin
            ferr_d = 1'b1;
          end else if (!(^{shift_q, par_q})) begin
            perr_d = 1'b1;
          end else begin
`ifdef PS2_EXT_DECODE_EN
            if (shift_q == PS2_PFX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_PFX_BRK) begin
              brk_d = 1'b1;
            end else begin
              push_d    = 1'b1;
              push_ev_d = '{ext: ext_q, brk: brk_q, code: shift_q};
              ext_d     = 1'b0;
              brk_d     = 1'b0;
            end
`else
            push_d    = 1'b1;
            push_ev_d = '{ext: 1'b0, brk: 1'b0, code: shift_q};
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef PS2_EXT_DECODE_EN
    // A broken frame invalidates any pending prefix.
    if (perr_d | ferr_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
`endif
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_event_t))
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .push_i     (push_q),
    .wdata_i    (push_ev_q),
    .pop_i      (EV_READY),
    .rdata_o    (EV_DATA),
    .valid_o    (EV_VALID),
    .full_o     (w_fifo_full),
    .count_o    (COUNT),
    .overflow_o (OVERFLOW)
  );

  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;
  assign BUSY       = (state_q != IDLE) | (w_fifo_full & 1'b0);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_event_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_ps2_rx_event_queue                                  |
// | Brief   : Directed self-checking bench for ps2_rx_event_queue.   |
// |           Expectations follow PS2_EXT_DECODE_EN when defined.    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_ps2_rx_event_queue;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 5000;
  localparam int FIFO_DEPTH  = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic       EV_READY = 1'b1;
  logic [9:0] EV_DATA;
  logic       EV_VALID;
  logic [$clog2(FIFO_DEPTH):0] COUNT;
  logic       PARITY_ERR, FRAME_ERR, OVERFLOW, BUSY;

  int n_vec = 0;
  int n_bad = 0;
  int n_perr = 0;
  int n_ferr = 0;
  logic [9:0] ev_log[$];

  int base, perr0, ferr0;

  ps2_rx_event_queue #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PS2_CLK    (PS2_CLK),
    .PS2_DATA   (PS2_DATA),
    .EV_DATA    (EV_DATA),
    .EV_VALID   (EV_VALID),
    .EV_READY   (EV_READY),
    .COUNT      (COUNT),
    .PARITY_ERR (PARITY_ERR),
    .FRAME_ERR  (FRAME_ERR),
    .OVERFLOW   (OVERFLOW),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Log popped events and error pulses, sampled on the inactive edge.
  always @(negedge CLK) begin
    if (EV_VALID && EV_READY) ev_log.push_back(EV_DATA);
    if (PARITY_ERR) n_perr++;
    if (FRAME_ERR)  n_ferr++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev_at(input int i);
    if (i < ev_log.size()) return {22'b0, ev_log[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic ps2_bit(input logic b);
    PS2_DATA = b;
    repeat (10) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (20) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  // Send the first nbits of a frame: start, data LSB-first, odd parity, stop.
  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_bit, input int nbits);
    logic [10:0] f;
    f = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    PS2_DATA = 1'b1;
    repeat (20) @(negedge CLK);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ev_data"},  {22'b0, EV_DATA}, 32'h0);
    chk({tag, "_ev_valid"}, {31'b0, EV_VALID}, 32'h0);
    chk({tag, "_count"},    {28'b0, COUNT}, 32'h0);
    chk({tag, "_perr"},     {31'b0, PARITY_ERR}, 32'h0);
    chk({tag, "_ferr"},     {31'b0, FRAME_ERR}, 32'h0);
    chk({tag, "_ovf"},      {31'b0, OVERFLOW}, 32'h0);
    chk({tag, "_busy"},     {31'b0, BUSY}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk_reset_outputs("rst");
    RESET = 1'b0;
    repeat (5) @(negedge CLK);

    // Make / break / make of key 0x75.
    base = ev_log.size(); perr0 = n_perr; ferr0 = n_ferr;
    send_frame(8'h75, 1'b0, 1'b1, 11);
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    send_frame(8'h75, 1'b0, 1'b1, 11);
`ifdef PS2_EXT_DECODE_EN
    chk("brk_n_ev", ev_log.size() - base, 2);
    chk("brk_ev0", ev_at(base), 32'h075);
    chk("brk_ev1", ev_at(base + 1), 32'h175);
`else
    chk("raw_n_ev", ev_log.size() - base, 3);
    chk("raw_ev0", ev_at(base), 32'h075);
    chk("raw_ev1", ev_at(base + 1), 32'h0F0);
    chk("raw_ev2", ev_at(base + 2), 32'h075);
`endif
    chk("brk_no_perr", n_perr - perr0, 0);
    chk("brk_no_ferr", n_ferr - ferr0, 0);

    // Extended break sequence E0 F0 75.
    base = ev_log.size();
    send_frame(8'hE0, 1'b0, 1'b1, 11);
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    send_frame(8'h75, 1'b0, 1'b1, 11);
`ifdef PS2_EXT_DECODE_EN
    chk("ext_n_ev", ev_log.size() - base, 1);
    chk("ext_ev0", ev_at(base), 32'h375);
`else
    chk("ext_n_ev", ev_log.size() - base, 3);
    chk("ext_ev0", ev_at(base), 32'h0E0);
    chk("ext_ev1", ev_at(base + 1), 32'h0F0);
    chk("ext_ev2", ev_at(base + 2), 32'h075);
`endif

    // Bad parity, then bad stop bit.
    base = ev_log.size(); perr0 = n_perr; ferr0 = n_ferr;
    send_frame(8'h75, 1'b1, 1'b1, 11);
    chk("par_perr", n_perr - perr0, 1);
    chk("par_ferr", n_ferr - ferr0, 0);
    chk("par_count", {28'b0, COUNT}, 32'h0);
    send_frame(8'h75, 1'b0, 1'b0, 11);
    chk("stop_ferr", n_ferr - ferr0, 1);
    chk("stop_perr", n_perr - perr0, 1);
    chk("stop_count", {28'b0, COUNT}, 32'h0);
    chk("err_no_ev", ev_log.size() - base, 0);

    // Stalled frame times out, then a clean frame decodes.
    ferr0 = n_ferr;
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    chk("tmo_busy_mid", {31'b0, BUSY}, 32'h1);
    repeat (TIMEOUT_CYC + 10) @(negedge CLK);
    chk("tmo_ferr", n_ferr - ferr0, 1);
    chk("tmo_busy", {31'b0, BUSY}, 32'h0);
    base = ev_log.size();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    chk("tmo_next_n", ev_log.size() - base, 1);
    chk("tmo_next_ev", ev_at(base), 32'h01C);

    // Fill past capacity with the reader stalled.
    EV_READY = 1'b0;
    for (int k = 1; k <= FIFO_DEPTH + 1; k++) send_frame(8'(k), 1'b0, 1'b1, 11);
    chk("ovf_count", {28'b0, COUNT}, 32'h8);
    chk("ovf_flag", {31'b0, OVERFLOW}, 32'h1);
    chk("ovf_valid", {31'b0, EV_VALID}, 32'h1);
    chk("ovf_head", {22'b0, EV_DATA}, 32'h001);
    repeat (3) @(negedge CLK);
    chk("ovf_head_hold", {22'b0, EV_DATA}, 32'h001);
    base = ev_log.size();
    EV_READY = 1'b1;
    repeat (12) @(negedge CLK);
    chk("drain_n", ev_log.size() - base, 8);
    for (int k = 0; k < FIFO_DEPTH; k++) chk($sformatf("drain_ev%0d", k), ev_at(base + k), 32'(k + 1));
    chk("drain_count", {28'b0, COUNT}, 32'h0);
    chk("drain_ovf_sticky", {31'b0, OVERFLOW}, 32'h1);

    // Reset in the middle of a frame.
    send_frame(8'h5A, 1'b0, 1'b1, 4);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk_reset_outputs("midrst");
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    base = ev_log.size();
    send_frame(8'h5A, 1'b0, 1'b1, 11);
    chk("post_rst_n", ev_log.size() - base, 1);
    chk("post_rst_ev", ev_at(base), 32'h05A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
